// File: rtl/fixed_bias_add_join.sv
// Joins an accumulator stream with a bias stream and adds each bias lane after aligning it to the data fraction.
// The signed sum saturates to the output width and is held in a 2-entry skid buffer.
module fixed_bias_add_join #(
  parameter int DATA_IN_PRECISION_0  = 32,
  parameter int DATA_IN_PRECISION_1  = 16,
  parameter int BIAS_PRECISION_0     = 16,
  parameter int BIAS_PRECISION_1     = 3,
  parameter int DATA_OUT_PRECISION_0 = 32,
  parameter int PARALLELISM_DIM_0    = 1,
  parameter int PARALLELISM_DIM_1    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_IN_PRECISION_0-1:0]  data_in  [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic [BIAS_PRECISION_0-1:0]     bias     [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0],
  input  logic                            bias_valid,
  output logic                            bias_ready,
  output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0],
  output logic                            data_out_valid,
  input  logic                            data_out_ready
);

  localparam int N         = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int DO_W      = DATA_OUT_PRECISION_0;
  localparam int SHIFT     = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
  localparam int BIAS_AL_W = BIAS_PRECISION_0 + SHIFT;
  localparam int SUM_WIDTH = ((DATA_IN_PRECISION_0 > BIAS_AL_W) ? DATA_IN_PRECISION_0 : BIAS_AL_W) + 1;
  // Comparison width always exceeds both the sum and the output so the bounds fit with headroom.
  localparam int CMP_W     = ((SUM_WIDTH > DO_W) ? SUM_WIDTH : DO_W) + 1;

  localparam logic signed [CMP_W-1:0] OUT_MAX = {{(CMP_W-DO_W+1){1'b0}}, {(DO_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] OUT_MIN = {{(CMP_W-DO_W+1){1'b1}}, {(DO_W-1){1'b0}}};

  if (BIAS_PRECISION_1 > DATA_IN_PRECISION_1) begin : g_param_check
    $error("BIAS_PRECISION_1 must not exceed DATA_IN_PRECISION_1");
  end

  logic [DO_W-1:0] lane_res [N-1:0];

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [SUM_WIDTH-1:0] d_ext;
    logic signed [SUM_WIDTH-1:0] b_ext;
    logic signed [SUM_WIDTH-1:0] sum;
    logic signed [CMP_W-1:0]     sum_w;

    assign d_ext = SUM_WIDTH'($signed(data_in[g]));
    assign b_ext = SUM_WIDTH'($signed(bias[g])) <<< SHIFT;
    assign sum   = d_ext + b_ext;
    assign sum_w = CMP_W'(sum);

    assign lane_res[g] = (sum_w > OUT_MAX) ? OUT_MAX[DO_W-1:0] :
                         (sum_w < OUT_MIN) ? OUT_MIN[DO_W-1:0] :
                                             sum_w[DO_W-1:0];
  end

  logic [1:0]      occ_q, occ_d;
  logic [DO_W-1:0] head_q [N-1:0];
  logic [DO_W-1:0] head_d [N-1:0];
  logic [DO_W-1:0] tail_q [N-1:0];
  logic [DO_W-1:0] tail_d [N-1:0];
  logic            space;
  logic            fire;
  logic            pop;

  // Readies depend only on registered occupancy and the opposite valid, never on data_out_ready.
  assign space          = (occ_q != 2'd2);
  assign data_in_ready  = ~rst & bias_valid & space;
  assign bias_ready     = ~rst & data_in_valid & space;
  assign fire           = ~rst & data_in_valid & bias_valid & space;
  assign data_out_valid = (occ_q != 2'd0);
  assign pop            = data_out_valid & data_out_ready;
  assign data_out       = head_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (fire && !pop) begin
      if (occ_q == 2'd0) head_d = lane_res;
      else               tail_d = lane_res;
      occ_d = occ_q + 2'd1;
    end else if (!fire && pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end else if (fire && pop) begin
      if (occ_q == 2'd1) begin
        head_d = lane_res;
      end else begin
        head_d = tail_q;
        tail_d = lane_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '{default: '0};
      tail_q <= '{default: '0};
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: tb/tb_fixed_bias_add_join.sv
// Randomized and directed bench for fixed_bias_add_join against a queue-based reference model.
module tb_fixed_bias_add_join;

  localparam int DI0 = 32, DI1 = 16, BP0 = 16, BP1 = 3, DO0 = 32, N = 1;
  localparam int SHIFT = DI1 - BP1;

  typedef logic [N*DO0-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [DI0-1:0] data_in  [N-1:0];
  logic           data_in_valid;
  logic           data_in_ready;
  logic [BP0-1:0] bias     [N-1:0];
  logic           bias_valid;
  logic           bias_ready;
  logic [DO0-1:0] data_out [N-1:0];
  logic           data_out_valid;
  logic           data_out_ready;

  fixed_bias_add_join #(
    .DATA_IN_PRECISION_0(DI0), .DATA_IN_PRECISION_1(DI1),
    .BIAS_PRECISION_0(BP0), .BIAS_PRECISION_1(BP1),
    .DATA_OUT_PRECISION_0(DO0), .PARALLELISM_DIM_0(N), .PARALLELISM_DIM_1(1)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t exp_q [$];
  vec_t got_q [$];
  int   max_occ  = 0;
  int   fire_cnt = 0;
  bit   last_fire, last_pop;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Plain-integer reference: scale bias by 2^SHIFT, add, clamp to the signed output range.
  function automatic logic [DO0-1:0] model_lane(logic [DI0-1:0] d, logic [BP0-1:0] b);
    longint s, mx, mn;
    s  = longint'($signed(d)) + longint'($signed(b)) * (longint'(1) << SHIFT);
    mx = (longint'(1) << (DO0-1)) - 1;
    mn = -(longint'(1) << (DO0-1));
    if (s > mx) s = mx;
    if (s < mn) s = mn;
    return s[DO0-1:0];
  endfunction

  function automatic vec_t model_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i*DO0 +: DO0] = model_lane(data_in[i], bias[i]);
    return v;
  endfunction

  // One clock: compare at the falling edge, then advance the model alongside the rising edge.
  task automatic cycle();
    vec_t act;
    @(negedge clk);
    for (int i = 0; i < N; i++) act[i*DO0 +: DO0] = data_out[i];
    check("out_valid", data_out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("data_out", act, exp_q[0]);
    check("data_in_ready", data_in_ready, bias_valid && exp_q.size() < 2);
    check("bias_ready", bias_ready, data_in_valid && exp_q.size() < 2);
    last_fire = data_in_valid && bias_valid && exp_q.size() < 2;
    last_pop  = exp_q.size() != 0 && data_out_ready;
    if (last_pop) begin
      got_q.push_back(act);
      void'(exp_q.pop_front());
    end
    if (last_fire) begin
      exp_q.push_back(model_vec());
      fire_cnt++;
    end
    if (exp_q.size() > max_occ) max_occ = exp_q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic single(logic [31:0] d, logic [15:0] b, logic [31:0] lit, string name);
    data_in[0] = d; bias[0] = b;
    data_in_valid = 1; bias_valid = 1; data_out_ready = 1;
    cycle();
    data_in_valid = 0; bias_valid = 0;
    check({name, "_valid"}, data_out_valid, 1);
    check({name, "_lit"}, data_out[0], lit);
    cycle();
    check({name, "_pulse"}, data_out_valid, 0);
  endtask

  initial begin
    int k, f0, pops;
    rst = 1;
    data_in = '{default: '0}; bias = '{default: '0};
    data_in_valid = 0; bias_valid = 0; data_out_ready = 0;
    #12;
    data_in_valid = 1; bias_valid = 1;
    #1;
    check("rst_valid", data_out_valid, 0);
    check("rst_din_ready", data_in_ready, 0);
    check("rst_bias_ready", bias_ready, 0);
    check("rst_data_out", data_out[0], 0);
    data_in_valid = 0; bias_valid = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    single(32'h0002_0000, 16'h0008, 32'h0003_0000, "basic");
    single(32'h7FFF_0000, 16'h7FFF, 32'h7FFF_FFFF, "pos_sat");
    single(32'h8000_0000, 16'hFFF8, 32'h8000_0000, "neg_sat");
    single(32'hFFFF_0000, 16'h0010, 32'h0001_0000, "mixed_sign");

    // Join gating: bias alone must never be acknowledged.
    bias[0] = 16'h0005; data_in[0] = 32'h0000_1000;
    bias_valid = 1; data_in_valid = 0;
    for (int c = 0; c < 5; c++) begin
      check("join_bias_ready", bias_ready, 0);
      cycle();
      check("join_no_out", data_out_valid, 0);
    end
    data_in_valid = 1;
    #1;
    check("join_both_ready", {bias_ready, data_in_ready}, 2'b11);
    f0 = fire_cnt;
    cycle();
    data_in_valid = 0; bias_valid = 0;
    check("join_one_fire", fire_cnt - f0, 1);
    cycle(); cycle();

    // Backpressure stream with a 3-cycle downstream stall.
    got_q.delete(); max_occ = 0; k = 0;
    for (int c = 0; c < 200 && !(k == 32 && exp_q.size() == 0); c++) begin
      data_out_ready = !(c >= 10 && c < 13);
      data_in_valid = (k < 32); bias_valid = (k < 32);
      data_in[0] = 0; bias[0] = 16'(k);
      cycle();
      if (last_fire) k++;
    end
    data_in_valid = 0; bias_valid = 0; data_out_ready = 1;
    check("bp_beats_sent", k, 32);
    check("bp_beats_recv", got_q.size(), 32);
    check("bp_peak_occ", max_occ, 2);
    for (int i = 0; i < 32 && i < got_q.size(); i++)
      check("bp_order", got_q[i], vec_t'(i << SHIFT));

    // Full throughput: 32 fires then 32 back-to-back outputs.
    got_q.delete(); pops = 0; f0 = fire_cnt;
    for (int c = 0; c < 33; c++) begin
      data_in_valid = (c < 32); bias_valid = (c < 32); data_out_ready = 1;
      data_in[0] = $urandom; bias[0] = 16'($urandom);
      cycle();
      if (c >= 1 && last_pop) pops++;
    end
    data_in_valid = 0; bias_valid = 0;
    check("tp_fires", fire_cnt - f0, 32);
    check("tp_consecutive_pops", pops, 32);

    // Async reset with two entries held.
    data_out_ready = 0; data_in_valid = 1; bias_valid = 1;
    data_in[0] = 32'h0000_0100; bias[0] = 16'h0001;
    cycle(); cycle();
    check("pre_rst_occ", exp_q.size(), 2);
    rst = 1;
    #1;
    check("arst_valid", data_out_valid, 0);
    check("arst_din_ready", data_in_ready, 0);
    check("arst_bias_ready", bias_ready, 0);
    check("arst_data_out", data_out[0], 0);
    exp_q.delete();
    #1 rst = 0;
    data_out_ready = 1;
    data_in[0] = 32'h0001_0000; bias[0] = 16'hFFF8;
    cycle();
    data_in_valid = 0; bias_valid = 0;
    check("post_rst_lit", {data_out_valid, data_out[0]}, {1'b1, 32'h0000_0000});
    cycle();

    // Randomized traffic with occasional extreme operands.
    for (int c = 0; c < 400; c++) begin
      data_in_valid  = ($urandom_range(0, 9) < 7);
      bias_valid     = ($urandom_range(0, 9) < 7);
      data_out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 5))
        0: data_in[0] = 32'h7FFF_FFF0;
        1: data_in[0] = 32'h8000_0010;
        default: data_in[0] = $urandom;
      endcase
      bias[0] = 16'($urandom);
      cycle();
    end
    data_in_valid = 0; bias_valid = 0; data_out_ready = 1;
    for (int c = 0; c < 4; c++) cycle();
    check("drain_empty", data_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
